// File: rtl/mpq_host_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : mpq_host_driver_if
// Brief    : Engine-side bus between the MPQ host driver and the MPQ engine.
// Revision : 1.0  initial release
// ============================================================================
interface mpq_host_driver_if;
    logic       data_valid;
    logic [7:0] data;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [7:0] index;
    logic [7:0] value;
    logic       busy;
    logic       RAM_valid;
    logic [7:0] RAM_A;
    logic [7:0] RAM_D;
    logic       done;

    modport master (
        output data_valid, data, cmd_valid, cmd, index, value,
        input  busy, RAM_valid, RAM_A, RAM_D, done
    );

    modport slave (
        input  data_valid, data, cmd_valid, cmd, index, value,
        output busy, RAM_valid, RAM_A, RAM_D, done
    );
endinterface
`default_nettype wire

// File: rtl/mpq_host_driver.sv
`default_nettype none
// ============================================================================
// Module   : mpq_host_driver
// Brief    : Host-side initiator for the MPQ engine: buffers a data burst,
//            issues queue commands and forwards the RAM write-back stream.
//            Optional watchdog enabled by defining MPQ_DRV_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module mpq_host_driver #(
    parameter int DEPTH   = 255,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              op_valid,
    input  logic [2:0]        op_cmd,
    input  logic [7:0]        op_index,
    input  logic [7:0]        op_value,
    output logic              op_ready,
    mpq_host_driver_if.master eng,
    output logic              res_valid,
    output logic [7:0]        res_addr,
    output logic [7:0]        res_data,
    output logic              res_done,
    output logic              op_done,
    output logic              err
);

    localparam logic [7:0]      c_DEPTH    = 8'(DEPTH);
    localparam int              c_GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(GAP - 1);
    localparam logic [9:0]      c_TO_LAST  = 10'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_PUSH      = 3'd2,
        S_CMD       = 3'd3,
        S_WAIT_BUSY = 3'd4,
        S_WAIT_END  = 3'd5,
        S_GAP_S     = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [7:0]      r_buf [0:DEPTH-1];
    logic [7:0]      r_count;
    logic [7:0]      r_rd_ptr;
    logic [2:0]      r_cmd;
    logic [7:0]      r_index;
    logic [7:0]      r_value;
    logic            r_prev_done;
    logic            r_stale;
    logic [c_GW-1:0] r_gap;
    logic            r_res_valid;
    logic [7:0]      r_res_addr;
    logic [7:0]      r_res_data;
    logic            r_res_done;
    logic            r_op_done;
    logic            r_err;

    logic            w_ld_ready;
    logic            w_op_ready;
    logic            w_byte_acc;
    logic            w_op_acc;
    logic            w_bad_op;
    logic            w_push_adv;
    logic            w_push_end;
    logic            w_data_valid;
    logic            w_cmd_valid;
    logic            w_ram_fwd;
    logic            w_op_done_evt;
    logic            w_res_done_evt;
    logic            w_err_evt;
    logic            w_wdog_hit;

`ifdef MPQ_DRV_TIMEOUT_EN
    logic [9:0]      r_wdog;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else if (r_state == S_WAIT_BUSY || r_state == S_WAIT_END) begin
            r_wdog <= r_wdog + 10'd1;
        end else begin
            r_wdog <= '0;
        end
    end

    assign w_wdog_hit = (r_state == S_WAIT_BUSY || r_state == S_WAIT_END) &&
                        (r_wdog == c_TO_LAST);
`else
    logic [9:0]      w_unused_timeout;
    assign w_unused_timeout = c_TO_LAST;
    assign w_wdog_hit       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_ready     = 1'b0;
        w_op_ready     = 1'b0;
        w_byte_acc     = 1'b0;
        w_op_acc       = 1'b0;
        w_bad_op       = 1'b0;
        w_push_adv     = 1'b0;
        w_push_end     = 1'b0;
        w_data_valid   = 1'b0;
        w_cmd_valid    = 1'b0;
        w_ram_fwd      = 1'b0;
        w_op_done_evt  = 1'b0;
        w_res_done_evt = 1'b0;
        w_err_evt      = 1'b0;

        case (r_state)
            S_IDLE, S_LOAD: begin
                // Ready outputs are held low while reset is asserted.
                w_ld_ready = rst_n && (r_count < c_DEPTH);
                w_op_ready = rst_n && (r_state == S_IDLE) && (r_count == 8'd0) &&
                             !eng.busy && !ld_valid;
                w_byte_acc = ld_valid && w_ld_ready;
                w_op_acc   = op_valid && w_op_ready;
                if (w_byte_acc) begin
                    w_state_nxt = (ld_last || (r_count == c_DEPTH - 8'd1)) ? S_PUSH : S_LOAD;
                end else if (w_op_acc) begin
                    if (op_cmd > 3'd4) begin
                        w_bad_op      = 1'b1;
                        w_err_evt     = 1'b1;
                        w_op_done_evt = 1'b1;
                    end else begin
                        w_state_nxt = S_CMD;
                    end
                end
            end
            S_PUSH: begin
                w_data_valid = !eng.busy;
                if (!eng.busy) begin
                    w_push_adv = 1'b1;
                    if (r_rd_ptr == r_count - 8'd1) begin
                        w_push_end    = 1'b1;
                        w_op_done_evt = 1'b1;
                        w_state_nxt   = S_GAP_S;
                    end
                end
            end
            S_CMD: begin
                w_cmd_valid = 1'b1;
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (eng.busy) begin
                    w_state_nxt = S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                if (r_cmd != 3'd4) begin
                    if (!eng.busy) begin
                        w_op_done_evt = 1'b1;
                        w_state_nxt   = S_GAP_S;
                    end
                end else if (r_stale) begin
                    // done was already high at issue, so no edge will come: end on busy low.
                    if (!eng.busy) begin
                        w_op_done_evt  = 1'b1;
                        w_res_done_evt = 1'b1;
                        w_err_evt      = 1'b1;
                        w_state_nxt    = S_GAP_S;
                    end
                end else begin
                    w_ram_fwd = eng.RAM_valid && !eng.done;
                    if (eng.done && !r_prev_done) begin
                        w_op_done_evt  = 1'b1;
                        w_res_done_evt = 1'b1;
                        w_state_nxt    = S_GAP_S;
                    end
                end
            end
            S_GAP_S: begin
                if (r_gap == c_GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_wdog_hit && (w_state_nxt != S_GAP_S)) begin
            w_op_done_evt = 1'b1;
            w_err_evt     = 1'b1;
            w_state_nxt   = S_GAP_S;
        end
    end

    always_ff @(posedge clk) begin
        if (w_byte_acc) begin
            r_buf[r_count] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_cmd       <= '0;
            r_index     <= '0;
            r_value     <= '0;
            r_prev_done <= 1'b0;
            r_stale     <= 1'b0;
            r_gap       <= '0;
            r_res_valid <= 1'b0;
            r_res_addr  <= '0;
            r_res_data  <= '0;
            r_res_done  <= 1'b0;
            r_op_done   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_prev_done <= eng.done;
            r_op_done   <= w_op_done_evt;
            r_res_done  <= w_res_done_evt;
            r_res_valid <= w_ram_fwd;
            if (w_ram_fwd) begin
                r_res_addr <= eng.RAM_A;
                r_res_data <= eng.RAM_D;
            end
            if (w_err_evt) begin
                r_err <= 1'b1;
            end

            if (w_byte_acc) begin
                r_count <= r_count + 8'd1;
            end else if (w_push_end) begin
                r_count <= '0;
            end

            if (w_push_end) begin
                r_rd_ptr <= '0;
            end else if (w_push_adv) begin
                r_rd_ptr <= r_rd_ptr + 8'd1;
            end

            // Command fields stay on the engine bus until the transaction ends.
            if (w_op_acc && !w_bad_op) begin
                r_cmd   <= op_cmd;
                r_index <= op_index;
                r_value <= op_value;
            end else if ((r_state == S_WAIT_BUSY || r_state == S_WAIT_END) &&
                         (w_state_nxt == S_GAP_S)) begin
                r_cmd   <= '0;
                r_index <= '0;
                r_value <= '0;
            end

            if (r_state == S_CMD) begin
                r_stale <= eng.done;
            end

            r_gap <= (r_state == S_GAP_S) ? r_gap + 1'b1 : '0;
        end
    end

    assign ld_ready       = w_ld_ready;
    assign op_ready       = w_op_ready;
    assign eng.data_valid = w_data_valid;
    assign eng.data       = w_data_valid ? r_buf[r_rd_ptr] : 8'd0;
    assign eng.cmd_valid  = w_cmd_valid;
    assign eng.cmd        = r_cmd;
    assign eng.index      = r_index;
    assign eng.value      = r_value;
    assign res_valid      = r_res_valid;
    assign res_addr       = r_res_addr;
    assign res_data       = r_res_data;
    assign res_done       = r_res_done;
    assign op_done        = r_op_done;
    assign err            = r_err;

endmodule
`default_nettype wire
